// File: rtl/blit_addr_stepper.sv
// blit_addr_stepper: registered X/Y blitter pointer (IW integer + FW fraction bits).
// Each cycle it can accept one step. The step selects an operand, can negate it,
// and adds it to the held pointer modulo 2^(IW+FW).
// Optional macro ADDR_CLIP_EN adds the win_w/win_h/clr_clip ports and a sticky
// window flag. Without the macro, clip is tied low.
module blit_addr_stepper #(
  parameter int IW = 16,
  parameter int FW = 16,
  parameter int CW = 3
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          ld_v,
  input  logic [IW+FW-1:0]              ld_x,
  input  logic [IW+FW-1:0]              ld_y,
  input  logic                          step_v,
  output logic                          step_rdy,
  input  logic [2:0]                    sel,
  input  logic                          sub_x,
  input  logic                          sub_y,
  input  logic [CW-1:0]                 xconst,
  input  logic                          yconst,
  input  logic [IW-1:0]                 a1_step_x,
  input  logic [IW-1:0]                 a1_step_y,
  input  logic [(FW > 0 ? FW : 1)-1:0]  a1_stepf_x,
  input  logic [(FW > 0 ? FW : 1)-1:0]  a1_stepf_y,
  input  logic [IW-1:0]                 a2_step_x,
  input  logic [IW-1:0]                 a2_step_y,
  input  logic [IW-1:0]                 a1_inc_x,
  input  logic [IW-1:0]                 a1_inc_y,
  input  logic [(FW > 0 ? FW : 1)-1:0]  a1_incf_x,
  input  logic [(FW > 0 ? FW : 1)-1:0]  a1_incf_y,
`ifdef ADDR_CLIP_EN
  input  logic [IW-1:0]                 win_w,
  input  logic [IW-1:0]                 win_h,
  input  logic                          clr_clip,
`endif
  output logic [IW+FW-1:0]              ptr_x,
  output logic [IW+FW-1:0]              ptr_y,
  output logic                          done,
  output logic                          clip
);

  localparam int W   = IW + FW;
  localparam int FWP = (FW > 0) ? FW : 1;

  logic          rdy_en;
  logic          accept;
  logic [IW-1:0] xc_int;
  logic [IW-1:0] int_x, int_y;
  logic [FWP-1:0] frac_x, frac_y;
  logic [W-1:0]  raw_x, raw_y;
  logic [W-1:0]  op_x, op_y;
  logic [W-1:0]  next_x, next_y;

  assign step_rdy = rdy_en & ~ld_v;
  assign accept   = step_v & step_rdy;

  // X constant decode: 0 and the all-ones code both mean zero, otherwise 1 << (code-1)
  always_comb begin
    if (xconst == '0 || xconst == '1) xc_int = '0;
    else                              xc_int = IW'(1) << (xconst - CW'(1));
  end

  // Step operand selection, integer and fraction halves per axis
  always_comb begin
    int_x  = '0;
    int_y  = '0;
    frac_x = '0;
    frac_y = '0;
    case (sel)
      3'd0: begin
        int_x = a1_step_x;  frac_x = a1_stepf_x;
        int_y = a1_step_y;  frac_y = a1_stepf_y;
      end
      3'd1: begin
        int_x = a2_step_x;
        int_y = a2_step_y;
      end
      3'd2: begin
        int_x = a1_inc_x;   frac_x = a1_incf_x;
        int_y = a1_inc_y;   frac_y = a1_incf_y;
      end
      3'd3: begin
        int_x = xc_int;
        int_y = IW'(yconst);
      end
      default: ;
    endcase
  end

  // With FW=0 the fraction selects are dropped; the pointer is integer-only
  generate
    if (FW > 0) begin : g_frac
      assign raw_x = {int_x, frac_x};
      assign raw_y = {int_y, frac_y};
    end else begin : g_nofrac
      assign raw_x = int_x;
      assign raw_y = int_y;
    end
  endgenerate

  assign op_x   = sub_x ? ('0 - raw_x) : raw_x;
  assign op_y   = sub_y ? ('0 - raw_y) : raw_y;
  assign next_x = ptr_x + op_x;
  assign next_y = ptr_y + op_y;

  // Pointer, done pulse and post-reset ready enable
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rdy_en <= 1'b0;
      ptr_x  <= '0;
      ptr_y  <= '0;
      done   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      done   <= accept;
      if (ld_v) begin
        ptr_x <= ld_x;
        ptr_y <= ld_y;
      end else if (accept) begin
        ptr_x <= next_x;
        ptr_y <= next_y;
      end
    end
  end

`ifdef ADDR_CLIP_EN
  logic clip_q;

  // Sticky window flag; a set in the same cycle outranks any clear
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      clip_q <= 1'b0;
    end else if (accept && (next_x[W-1:FW] >= win_w || next_y[W-1:FW] >= win_h)) begin
      clip_q <= 1'b1;
    end else if (clr_clip || ld_v) begin
      clip_q <= 1'b0;
    end
  end

  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_blit_addr_stepper.sv
// Randomised self-checking bench for blit_addr_stepper (IW=16, FW=16, CW=3).
// The reference model works on plain integer arithmetic modulo 2^32.
module tb_blit_addr_stepper;

  localparam longint unsigned M = 64'h1_0000_0000;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        ld_v;
  logic [31:0] ld_x, ld_y;
  logic        step_v;
  logic        step_rdy;
  logic [2:0]  sel;
  logic        sub_x, sub_y;
  logic [2:0]  xconst;
  logic        yconst;
  logic [15:0] a1_step_x, a1_step_y, a1_stepf_x, a1_stepf_y;
  logic [15:0] a2_step_x, a2_step_y;
  logic [15:0] a1_inc_x, a1_inc_y, a1_incf_x, a1_incf_y;
`ifdef ADDR_CLIP_EN
  logic [15:0] win_w, win_h;
  logic        clr_clip;
`endif
  logic [31:0] ptr_x, ptr_y;
  logic        done;
  logic        clip;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  longint unsigned m_x, m_y;
  bit m_done, m_clip, m_live;

  blit_addr_stepper #(.IW(16), .FW(16), .CW(3)) dut (
    .sys_clk(sys_clk), .reset(reset), .ld_v(ld_v), .ld_x(ld_x), .ld_y(ld_y),
    .step_v(step_v), .step_rdy(step_rdy), .sel(sel), .sub_x(sub_x), .sub_y(sub_y),
    .xconst(xconst), .yconst(yconst),
    .a1_step_x(a1_step_x), .a1_step_y(a1_step_y),
    .a1_stepf_x(a1_stepf_x), .a1_stepf_y(a1_stepf_y),
    .a2_step_x(a2_step_x), .a2_step_y(a2_step_y),
    .a1_inc_x(a1_inc_x), .a1_inc_y(a1_inc_y),
    .a1_incf_x(a1_incf_x), .a1_incf_y(a1_incf_y),
`ifdef ADDR_CLIP_EN
    .win_w(win_w), .win_h(win_h), .clr_clip(clr_clip),
`endif
    .ptr_x(ptr_x), .ptr_y(ptr_y), .done(done), .clip(clip)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_done = 0; m_clip = 0; m_live = 0;
  endtask

  // model of one clock edge, computed from the operand rules
  task automatic model_edge();
    longint unsigned ox, oy, xv;
    bit acc;
    acc = step_v && !ld_v && m_live;
    xv  = (xconst == 0 || xconst == 7) ? 0 : (64'd1 << (xconst - 1));
    case (sel)
      3'd0:    begin ox = a1_step_x * 65536 + a1_stepf_x; oy = a1_step_y * 65536 + a1_stepf_y; end
      3'd1:    begin ox = a2_step_x * 65536;              oy = a2_step_y * 65536; end
      3'd2:    begin ox = a1_inc_x * 65536 + a1_incf_x;   oy = a1_inc_y * 65536 + a1_incf_y; end
      3'd3:    begin ox = xv * 65536;                     oy = yconst * 65536; end
      default: begin ox = 0; oy = 0; end
    endcase
    if (sub_x) ox = (M - ox) % M;
    if (sub_y) oy = (M - oy) % M;
    if (ld_v) begin
      m_x = ld_x; m_y = ld_y;
    end else if (acc) begin
      m_x = (m_x + ox) % M;
      m_y = (m_y + oy) % M;
    end
    m_done = acc;
`ifdef ADDR_CLIP_EN
    if (acc && ((m_x / 65536) >= win_w || (m_y / 65536) >= win_h)) m_clip = 1;
    else if (clr_clip || ld_v) m_clip = 0;
`endif
    m_live = 1;
  endtask

  // inputs already driven after a negedge; check ready, clock, check outputs
  task automatic run_cycle(input string tag);
    #1 check({tag, ".rdy"}, step_rdy, (m_live && !ld_v));
    @(posedge sys_clk);
    model_edge();
    #1;
    check({tag, ".x"},    ptr_x, m_x[31:0]);
    check({tag, ".y"},    ptr_y, m_y[31:0]);
    check({tag, ".done"}, done,  m_done);
    check({tag, ".clip"}, clip,  m_clip);
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    ld_v = 0; step_v = 0; sel = 3'd4; sub_x = 0; sub_y = 0;
    xconst = 0; yconst = 0;
`ifdef ADDR_CLIP_EN
    clr_clip = 0;
`endif
  endtask

  task automatic rand_inputs();
    ld_v   = ($urandom_range(0, 7) == 0);
    ld_x   = $urandom; ld_y = $urandom;
    step_v = ($urandom_range(0, 3) != 0);
    sel    = 3'($urandom_range(0, 7));
    sub_x  = 1'($urandom); sub_y = 1'($urandom);
    xconst = 3'($urandom); yconst = 1'($urandom);
    a1_step_x = 16'($urandom); a1_step_y = 16'($urandom);
    a1_stepf_x = 16'($urandom); a1_stepf_y = 16'($urandom);
    a2_step_x = 16'($urandom); a2_step_y = 16'($urandom);
    a1_inc_x = 16'($urandom); a1_inc_y = 16'($urandom);
    a1_incf_x = 16'($urandom); a1_incf_y = 16'($urandom);
`ifdef ADDR_CLIP_EN
    win_w = 16'($urandom); win_h = 16'($urandom);
    clr_clip = ($urandom_range(0, 7) == 0);
`endif
  endtask

  initial begin
    reset = 1;
    ld_x = '0; ld_y = '0;
    a1_step_x = '0; a1_step_y = '0; a1_stepf_x = '0; a1_stepf_y = '0;
    a2_step_x = '0; a2_step_y = '0; a1_inc_x = '0; a1_inc_y = '0;
    a1_incf_x = '0; a1_incf_y = '0;
`ifdef ADDR_CLIP_EN
    win_w = 16'hFFFF; win_h = 16'hFFFF;
`endif
    idle_inputs();
    model_reset();
    #2;
    check("rst.x", ptr_x, 32'h0);
    check("rst.y", ptr_y, 32'h0);
    check("rst.done", done, 1'b0);
    check("rst.rdy", step_rdy, 1'b0);
    check("rst.clip", clip, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 0;

    // load wins over a simultaneous step
    ld_v = 1; ld_x = 32'h0010_8000; ld_y = 32'h0;
    step_v = 1; sel = 3'd0; a1_step_x = 16'd5; a1_stepf_x = 16'h0;
    run_cycle("load");
    check("load.val", ptr_x, 32'h0010_8000);

    // fraction carry into integer
    idle_inputs();
    step_v = 1; sel = 3'd0; a1_step_x = 16'd1; a1_stepf_x = 16'h8000;
    run_cycle("carry");
    check("carry.val", ptr_x, 32'h0012_0000);
    check("carry.done", done, 1'b1);
    idle_inputs();
    run_cycle("carry_idle");
    check("carry.pulse", done, 1'b0);

    // constant operand, subtracted on X
    ld_v = 1; ld_x = 32'h0004_0000; ld_y = 32'h0;
    run_cycle("ld2");
    idle_inputs();
    step_v = 1; sel = 3'd3; xconst = 3'd3; yconst = 1; sub_x = 1;
    run_cycle("const");
    check("const.x", ptr_x, 32'h0);
    check("const.y", ptr_y, 32'h0001_0000);

    // wrap below zero, four back-to-back steps
    idle_inputs();
    step_v = 1; sel = 3'd1; a2_step_x = 16'd1; a2_step_y = 16'd0; sub_x = 1;
    run_cycle("wrap");
    check("wrap.val", ptr_x, 32'hFFFF_0000);
    for (int i = 0; i < 3; i++) begin
      run_cycle("burst");
      check("burst.done", done, 1'b1);
    end
    check("burst.val", ptr_x, 32'hFFFC_0000);
    idle_inputs();
    run_cycle("burst_idle");

`ifdef ADDR_CLIP_EN
    // window flag sets at the boundary and holds until cleared
    win_w = 16'h0020; win_h = 16'hFFFF;
    ld_v = 1; ld_x = 32'h001F_0000; ld_y = 32'h0;
    run_cycle("clip_ld");
    idle_inputs();
    step_v = 1; sel = 3'd1; a2_step_x = 16'd1; a2_step_y = 16'd0;
    run_cycle("clip_set");
    check("clip.set", clip, 1'b1);
    idle_inputs();
    run_cycle("clip_hold");
    check("clip.hold", clip, 1'b1);
    clr_clip = 1;
    run_cycle("clip_clr");
    check("clip.clr", clip, 1'b0);
    idle_inputs();
`endif

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      run_cycle("rand");
    end

    // asynchronous reset in the middle of a burst
    ld_v = 1; ld_x = 32'h1234_5678; ld_y = 32'h0ABC_DEF0;
    run_cycle("ar_ld");
    idle_inputs();
    step_v = 1; sel = 3'd2; a1_inc_x = 16'd3; a1_incf_x = 16'h1111;
    run_cycle("ar_step");
    @(posedge sys_clk);
    model_edge();
    #3 reset = 1;
    #1;
    model_reset();
    check("ar.x", ptr_x, 32'h0);
    check("ar.y", ptr_y, 32'h0);
    check("ar.done", done, 1'b0);
    check("ar.rdy", step_rdy, 1'b0);
    @(posedge sys_clk);
    #1 check("ar.held", ptr_x, 32'h0);
    @(negedge sys_clk);
    reset = 0;

    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      run_cycle("rand2");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
